// File: rtl/mmu_inst_utlb.sv
`default_nettype none
// ============================================================================
// Module   : mmu_inst_utlb
// Purpose  : Instruction-side MMU with a fully associative micro-TLB.
//            kseg0/kseg1 are translated by fixed mapping with no stall.
//            kuseg/kseg2/kseg3 are looked up in the micro-TLB in the same
//            cycle. A miss stalls fetch and refills from the joint TLB over
//            a level-held req / one-cycle ack handshake. A failed refill
//            raises a one-cycle TLB refill or TLB invalid exception.
// Optional : ITLB_PERF_EN adds the perf_hit_cnt / perf_miss_cnt counters.
// Ports    : clk, resetn (async, active low)
//            fetch side : i_en, i_vaddr, i_rdata, asid, flush, stallreq
//            bus side   : ibus_en, ibus_paddr, ibus_rdata, ibus_cached
//            JTLB side  : jtlb_req, jtlb_vpn, jtlb_ack, jtlb_hit,
//                         jtlb_valid, jtlb_g, jtlb_pfn, jtlb_cached
//            exceptions : exc_refill, exc_invalid
// Revision : 1.0 - initial release
// ============================================================================
module mmu_inst_utlb #(
  parameter int ENTRIES = 4,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_en,
  input  logic [31:0]       i_vaddr,
  output logic [31:0]       i_rdata,
  input  logic [ASID_W-1:0] asid,
  input  logic              flush,
  output logic              ibus_en,
  output logic [31:0]       ibus_paddr,
  input  logic [31:0]       ibus_rdata,
  output logic              ibus_cached,
  output logic              stallreq,
  output logic              jtlb_req,
  output logic [19:0]       jtlb_vpn,
  input  logic              jtlb_ack,
  input  logic              jtlb_hit,
  input  logic              jtlb_valid,
  input  logic              jtlb_g,
  input  logic [19:0]       jtlb_pfn,
  input  logic              jtlb_cached,
  output logic              exc_refill,
  output logic              exc_invalid
`ifdef ITLB_PERF_EN
  ,
  output logic [31:0]       perf_hit_cnt,
  output logic [31:0]       perf_miss_cnt
`endif
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Entry storage: valid bits carry a reset, payload fields do not.
  logic [ENTRIES-1:0] e_valid;
  logic [19:0]        e_vpn    [ENTRIES];
  logic [ASID_W-1:0]  e_asid   [ENTRIES];
  logic               e_g      [ENTRIES];
  logic [19:0]        e_pfn    [ENTRIES];
  logic               e_cached [ENTRIES];

  logic [IDX_W-1:0] victim;
  logic             hit_latched, valid_latched;
  logic             flush_pend;   // a flush was seen while waiting for ack
  logic             load_vpn;

  // ---------------- region decode and lookup ----------------
  logic        unmapped, kseg0;
  logic        hit, hit_cached;
  logic [19:0] hit_pfn;

  assign kseg0    = (i_vaddr[31:29] == 3'b100);
  assign unmapped = (i_vaddr[31:30] == 2'b10);

  // Ascending scan with a first-found guard: the lowest index wins.
  always_comb begin
    hit        = 1'b0;
    hit_pfn    = 20'd0;
    hit_cached = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!hit && e_valid[i] && (e_vpn[i] == i_vaddr[31:12]) &&
          (e_g[i] || (e_asid[i] == asid))) begin
        hit        = 1'b1;
        hit_pfn    = e_pfn[i];
        hit_cached = e_cached[i];
      end
    end
  end

  always_comb begin
    if (unmapped) begin
      ibus_paddr  = {3'b000, i_vaddr[28:0]};
      ibus_cached = kseg0;
    end else begin
      ibus_paddr  = {hit_pfn, i_vaddr[11:0]};
      ibus_cached = hit_cached;
    end
  end

  // Any flush seen during the refill, including one coinciding with ack,
  // turns the response into a silent retry.
  logic discard, refill_ok, we;
  assign discard   = flush_pend | flush;
  assign refill_ok = jtlb_hit & jtlb_valid;
  assign we        = (state == REFILL) & jtlb_ack & refill_ok & ~discard;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stallreq  = 1'b0;
    ibus_en   = 1'b0;
    load_vpn  = 1'b0;
    case (state)
      IDLE: begin
        if (i_en) begin
          if (!unmapped && !hit) begin
            state_nxt = REFILL;
            stallreq  = 1'b1;
            load_vpn  = 1'b1;
          end else begin
            ibus_en = 1'b1;
          end
        end
      end
      REFILL: begin
        stallreq = 1'b1;
        if (jtlb_ack) begin
          if (discard || refill_ok) state_nxt = IDLE;
          else                      state_nxt = FAULT;
        end
      end
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign jtlb_req    = (state == REFILL);
  assign exc_refill  = (state == FAULT) & ~hit_latched;
  assign exc_invalid = (state == FAULT) & hit_latched & ~valid_latched;
  assign i_rdata     = (i_en && state != FAULT) ? ibus_rdata : 32'd0;

  // ---------------- control registers ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      jtlb_vpn      <= 20'd0;
      hit_latched   <= 1'b0;
      valid_latched <= 1'b0;
      flush_pend    <= 1'b0;
      victim        <= '0;
      e_valid       <= '0;
    end else begin
      if (load_vpn) jtlb_vpn <= i_vaddr[31:12];
      if (state == REFILL && jtlb_ack) begin
        hit_latched   <= jtlb_hit;
        valid_latched <= jtlb_valid;
        flush_pend    <= 1'b0;
      end else if (state == REFILL && flush) begin
        flush_pend <= 1'b1;
      end
      if (flush) begin
        e_valid <= '0;
      end else if (we) begin
        e_valid[victim] <= 1'b1;
      end
      if (we) victim <= victim + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      e_vpn[victim]    <= jtlb_vpn;
      e_asid[victim]   <= asid;
      e_g[victim]      <= jtlb_g;
      e_pfn[victim]    <= jtlb_pfn;
      e_cached[victim] <= jtlb_cached;
    end
  end

`ifdef ITLB_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_hit_cnt  <= 32'd0;
      perf_miss_cnt <= 32'd0;
    end else if (state == IDLE && i_en && !unmapped) begin
      if (hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      else     perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmu_inst_utlb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmu_inst_utlb
// Purpose  : Directed self-checking bench for mmu_inst_utlb (ENTRIES=4).
//            Inputs change on the falling edge, outputs are sampled 1 ns
//            later, so every check sits well away from the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmu_inst_utlb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_en;
  logic [31:0] i_vaddr;
  logic [31:0] i_rdata;
  logic [7:0]  asid;
  logic        flush;
  logic        ibus_en;
  logic [31:0] ibus_paddr;
  logic [31:0] ibus_rdata;
  logic        ibus_cached;
  logic        stallreq;
  logic        jtlb_req;
  logic [19:0] jtlb_vpn;
  logic        jtlb_ack, jtlb_hit, jtlb_valid, jtlb_g, jtlb_cached;
  logic [19:0] jtlb_pfn;
  logic        exc_refill, exc_invalid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mmu_inst_utlb #(.ENTRIES(4), .ASID_W(8)) dut (
    .clk(clk), .resetn(resetn), .i_en(i_en), .i_vaddr(i_vaddr),
    .i_rdata(i_rdata), .asid(asid), .flush(flush), .ibus_en(ibus_en),
    .ibus_paddr(ibus_paddr), .ibus_rdata(ibus_rdata),
    .ibus_cached(ibus_cached), .stallreq(stallreq), .jtlb_req(jtlb_req),
    .jtlb_vpn(jtlb_vpn), .jtlb_ack(jtlb_ack), .jtlb_hit(jtlb_hit),
    .jtlb_valid(jtlb_valid), .jtlb_g(jtlb_g), .jtlb_pfn(jtlb_pfn),
    .jtlb_cached(jtlb_cached), .exc_refill(exc_refill),
    .exc_invalid(exc_invalid)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One-cycle lookup probe with no FSM transition (i_en dropped before edge).
  task automatic probe(input string tag, input logic [31:0] va,
                       input logic exp_hit, input logic [31:0] exp_pa);
    i_en    = 1'b1;
    i_vaddr = va;
    #1;
    check({tag, "_stall"}, {31'd0, stallreq}, {31'd0, ~exp_hit});
    if (exp_hit) check({tag, "_pa"}, ibus_paddr, exp_pa);
    i_en = 1'b0;
    cycle();
  endtask

  // Miss at va, wait in REFILL, then answer with the given response.
  // Returns at the falling edge after the ack cycle with i_en still high.
  task automatic refill(input string tag, input logic [31:0] va,
                        input logic hit, input logic valid, input logic g,
                        input logic [19:0] pfn, input logic cached,
                        input logic flush_mid, input logic flush_ack);
    i_en    = 1'b1;
    i_vaddr = va;
    #1;
    check({tag, "_miss_stall"}, {31'd0, stallreq}, 32'd1);
    cycle();
    #1;
    check({tag, "_req"}, {31'd0, jtlb_req}, 32'd1);
    check({tag, "_vpn"}, {12'd0, jtlb_vpn}, {12'd0, va[31:12]});
    if (flush_mid) begin
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      #1;
      check({tag, "_req_held"}, {31'd0, jtlb_req}, 32'd1);
    end
    cycle();
    jtlb_ack    = 1'b1;
    jtlb_hit    = hit;
    jtlb_valid  = valid;
    jtlb_g      = g;
    jtlb_pfn    = pfn;
    jtlb_cached = cached;
    flush       = flush_ack;
    cycle();
    jtlb_ack = 1'b0;
    flush    = 1'b0;
    #1;
  endtask

  initial begin
    resetn = 1'b0; i_en = 1'b0; i_vaddr = 32'd0; asid = 8'd5; flush = 1'b0;
    ibus_rdata = 32'hDEADBEEF; jtlb_ack = 1'b0; jtlb_hit = 1'b0;
    jtlb_valid = 1'b0; jtlb_g = 1'b0; jtlb_pfn = 20'd0; jtlb_cached = 1'b0;
    cycle(); cycle();
    #1;
    check("rst_req", {31'd0, jtlb_req}, 32'd0);
    check("rst_vpn", {12'd0, jtlb_vpn}, 32'd0);
    check("rst_excr", {31'd0, exc_refill}, 32'd0);
    check("rst_exci", {31'd0, exc_invalid}, 32'd0);
    resetn = 1'b1;
    cycle();

    // Unmapped segments
    i_en = 1'b1; i_vaddr = 32'hBFC00000; #1;
    check("kseg1_pa", ibus_paddr, 32'h1FC00000);
    check("kseg1_c", {31'd0, ibus_cached}, 32'd0);
    check("kseg1_stall", {31'd0, stallreq}, 32'd0);
    check("kseg1_en", {31'd0, ibus_en}, 32'd1);
    check("kseg1_rdata", i_rdata, 32'hDEADBEEF);
    i_vaddr = 32'h80001000; #1;
    check("kseg0_pa", ibus_paddr, 32'h00001000);
    check("kseg0_c", {31'd0, ibus_cached}, 32'd1);
    i_en = 1'b0; #1;
    check("noen_rdata", i_rdata, 32'd0);
    check("noen_en", {31'd0, ibus_en}, 32'd0);
    cycle();

    // First refill -> entry 0 (vpn 00400, asid 5, g 0)
    refill("r0", 32'h00400010, 1'b1, 1'b1, 1'b0, 20'h12345, 1'b1, 1'b0, 1'b0);
    check("r0_pa", ibus_paddr, 32'h12345010);
    check("r0_stall", {31'd0, stallreq}, 32'd0);
    check("r0_c", {31'd0, ibus_cached}, 32'd1);
    check("r0_req_drop", {31'd0, jtlb_req}, 32'd0);
    check("r0_en", {31'd0, ibus_en}, 32'd1);
    i_vaddr = 32'h00400FFC; #1;
    check("r0b_pa", ibus_paddr, 32'h12345FFC);
    check("r0b_stall", {31'd0, stallreq}, 32'd0);
    i_en = 1'b0;
    cycle();

    // Refill exception (jtlb_hit=0)
    refill("fr", 32'h00500000, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    check("fr_excr", {31'd0, exc_refill}, 32'd1);
    check("fr_exci", {31'd0, exc_invalid}, 32'd0);
    check("fr_en", {31'd0, ibus_en}, 32'd0);
    check("fr_stall", {31'd0, stallreq}, 32'd0);
    check("fr_rdata", i_rdata, 32'd0);
    i_en = 1'b0;
    cycle(); #1;
    check("fr_pulse_end", {31'd0, exc_refill}, 32'd0);
    probe("fr_retry", 32'h00500000, 1'b0, 32'd0);

    // Invalid exception (hit=1, valid=0)
    refill("fi", 32'h00600000, 1'b1, 1'b0, 1'b0, 20'h66666, 1'b0, 1'b0, 1'b0);
    check("fi_exci", {31'd0, exc_invalid}, 32'd1);
    check("fi_excr", {31'd0, exc_refill}, 32'd0);
    check("fi_en", {31'd0, ibus_en}, 32'd0);
    i_en = 1'b0;
    cycle(); #1;
    check("fi_pulse_end", {31'd0, exc_invalid}, 32'd0);
    probe("fi_retry", 32'h00600000, 1'b0, 32'd0);

    // ASID matching; global entry -> entry 1
    asid = 8'd6;
    probe("asid6", 32'h00400010, 1'b0, 32'd0);
    refill("rg", 32'h00700000, 1'b1, 1'b1, 1'b1, 20'h00777, 1'b0, 1'b0, 1'b0);
    i_en = 1'b0;
    cycle();
    asid = 8'd9;
    probe("glob9", 32'h00700123, 1'b1, 32'h00777123);
    asid = 8'd5;
    probe("asid5", 32'h00400010, 1'b1, 32'h12345010);

    // Fill entries 2,3, then wrap to 0 (evicts 00400) and 1 (evicts 00700)
    refill("r2", 32'h00801000, 1'b1, 1'b1, 1'b0, 20'hA0801, 1'b0, 1'b0, 1'b0);
    i_en = 1'b0; cycle();
    refill("r3", 32'h00802000, 1'b1, 1'b1, 1'b0, 20'hA0802, 1'b0, 1'b0, 1'b0);
    i_en = 1'b0; cycle();
    refill("r4", 32'h00803000, 1'b1, 1'b1, 1'b0, 20'hA0803, 1'b0, 1'b0, 1'b0);
    i_en = 1'b0; cycle();
    probe("evict0", 32'h00400010, 1'b0, 32'd0);
    probe("keep_g", 32'h00700004, 1'b1, 32'h00777004);
    refill("r5", 32'h00804000, 1'b1, 1'b1, 1'b0, 20'hA0804, 1'b0, 1'b0, 1'b0);
    i_en = 1'b0; cycle();
    probe("evict1", 32'h00700004, 1'b0, 32'd0);
    probe("h801", 32'h00801008, 1'b1, 32'hA0801008);
    probe("h802", 32'h00802008, 1'b1, 32'hA0802008);
    probe("h803", 32'h00803008, 1'b1, 32'hA0803008);
    probe("h804", 32'h00804008, 1'b1, 32'hA0804008);

    // Flush mid-refill: response discarded, no exception, retry misses
    refill("fm", 32'h00900000, 1'b1, 1'b1, 1'b0, 20'h99999, 1'b0, 1'b1, 1'b0);
    check("fm_excr", {31'd0, exc_refill}, 32'd0);
    check("fm_exci", {31'd0, exc_invalid}, 32'd0);
    check("fm_retry_stall", {31'd0, stallreq}, 32'd1);
    check("fm_req_drop", {31'd0, jtlb_req}, 32'd0);
    i_en = 1'b0; cycle();
    probe("fm_gone801", 32'h00801008, 1'b0, 32'd0);

    // Flush coinciding with a writing ack: nothing written
    refill("fa", 32'h00B00000, 1'b1, 1'b1, 1'b0, 20'hBBBBB, 1'b0, 1'b0, 1'b1);
    check("fa_stall", {31'd0, stallreq}, 32'd1);
    check("fa_excr", {31'd0, exc_refill}, 32'd0);
    i_en = 1'b0; cycle();

    // Flush while idle
    refill("ri", 32'h00A00000, 1'b1, 1'b1, 1'b0, 20'h0AAAA, 1'b1, 1'b0, 1'b0);
    check("ri_pa", ibus_paddr, 32'h0AAAA000);
    i_en = 1'b0; cycle();
    probe("ri_hit", 32'h00A00010, 1'b1, 32'h0AAAA010);
    flush = 1'b1; cycle(); flush = 1'b0;
    probe("ri_flushed", 32'h00A00010, 1'b0, 32'd0);
    probe("fa_nowrite", 32'h00B00000, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
